// File: rtl/vedic_seq_mult_pkg.sv
// Shared definitions for the sequential vedic multiplier: FSM encoding,
// digit width and the 2x2 vedic primitive used to build the 4x4 tile.
package vedic_seq_mult_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Urdhva-tiryagbhyam on 2-bit digits: vertical, crosswise, vertical.
   function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] z);
      logic t1, t2, t3, c1;
      t1 = x[1] & z[0];
      t2 = x[0] & z[1];
      t3 = x[1] & z[1];
      c1 = t1 & t2;
      return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & z[0]};
   endfunction

endpackage

// File: rtl/vedic_4x4.sv
// Combinational 4x4 unsigned vedic multiplier tile built from four 2x2 blocks.
module vedic_4x4
   import vedic_seq_mult_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   logic [3:0] q0, q1, q2, q3;
   logic [5:0] mid;

   assign q0 = vedic_2x2(a[1:0], b[1:0]);
   assign q1 = vedic_2x2(a[3:2], b[1:0]);
   assign q2 = vedic_2x2(a[1:0], b[3:2]);
   assign q3 = vedic_2x2(a[3:2], b[3:2]);

   // Everything above bit 1 of the product, aligned to p[7:2].
   assign mid = {2'b00, q1} + {2'b00, q2} + {4'b0000, q0[3:2]};

   assign p = {mid + {q3, 2'b00}, q0[1:0]};

endmodule

// File: rtl/vedic_seq_mult.sv
// WIDTH x WIDTH unsigned multiplier that walks one vedic_4x4 tile over all
// digit pairs (N*N cycles) and shift-accumulates the partial products.
module vedic_seq_mult
   import vedic_seq_mult_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   y,
   output logic                 busy
);

   localparam int N  = WIDTH / DIGIT_W;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if ((WIDTH % DIGIT_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("vedic_seq_mult: WIDTH must be a multiple of 4 and at least 8");
   end

   state_t               state, state_nx;
   logic [WIDTH-1:0]     a_reg, b_reg;
   logic [2*WIDTH-1:0]   acc, pp_shift;
   logic [CW-1:0]        i_cnt, j_cnt;
   logic [DIGIT_W-1:0]   a_dig, b_dig;
   logic [7:0]           p;
   logic                 accept, last;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; a producer holds valid and data stable until that edge.
   assign in_ready  = rst_n && (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state == ST_RUN);
   assign y         = acc;
   assign accept    = in_valid && in_ready;
   assign last      = (i_cnt == LAST) && (j_cnt == LAST);

   assign a_dig    = DIGIT_W'(a_reg >> (DIGIT_W * i_cnt));
   assign b_dig    = DIGIT_W'(b_reg >> (DIGIT_W * j_cnt));
   assign pp_shift = (2*WIDTH)'(p) << (DIGIT_W * (i_cnt + j_cnt));

   vedic_4x4 u_tile (
      .a (a_dig),
      .b (b_dig),
      .p (p)
   );

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (accept)    state_nx = ST_RUN;
         ST_RUN:  if (last)      state_nx = ST_DONE;
         ST_DONE: if (out_ready) state_nx = ST_IDLE;
         default:                state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         i_cnt <= '0;
         j_cnt <= '0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_reg <= a;
                  b_reg <= b;
                  acc   <= '0;
                  i_cnt <= '0;
                  j_cnt <= '0;
               end
            end
            ST_RUN: begin
               acc <= acc + pp_shift;
               // j is the inner digit index; both wrap to zero after the last pair.
               if (j_cnt == LAST) begin
                  j_cnt <= '0;
                  i_cnt <= (i_cnt == LAST) ? '0 : i_cnt + 1'b1;
               end else begin
                  j_cnt <= j_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
